// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: oversampling UART receiver with 3-sample majority vote,
// optional even/odd parity check and stop-bit framing check.
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  RX_IN,
   input  logic                  Parity_EN,
   input  logic                  Parity_TYPE,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  Parity_Error,
   output logic                  Stop_Error,
   output logic                  Busy
);
   localparam int EW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH);
   localparam int M = OVERSAMPLE / 2;
   localparam logic [EW-1:0] E_ONE  = EW'(1);
   localparam logic [EW-1:0] E_PRE  = EW'(M - 1);
   localparam logic [EW-1:0] E_MID  = EW'(M);
   localparam logic [EW-1:0] E_VOTE = EW'(M + 1);
   localparam logic [EW-1:0] E_LAST = EW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

   state_t                state_q, state_d;
   logic [1:0]            sync_q;
   logic                  rx_s;
   logic [EW-1:0]         edge_q, edge_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
   logic                  s0_q, s0_d, s1_q, s1_d;
   logic                  pen_q, pen_d, ptype_q, ptype_d, perr_q, perr_d;
   logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d, busy_q;
   logic                  vote, at_vote, at_last;

   assign rx_s    = sync_q[1];
   assign at_vote = edge_q == E_VOTE;
   assign at_last = edge_q == E_LAST;
   // third sample is the live line value in the vote cycle
   assign vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

   always_comb begin
      state_d = state_q;
      edge_d  = at_last ? '0 : edge_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      s0_d    = edge_q == E_PRE ? rx_s : s0_q;
      s1_d    = edge_q == E_MID ? rx_s : s1_q;
      pen_d   = pen_q;
      ptype_d = ptype_q;
      perr_d  = perr_q;
      dv_d    = 1'b0;
      pe_d    = 1'b0;
      se_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            edge_d = '0;
            if (!rx_s) begin
               state_d = START;
               edge_d  = E_ONE;
               pen_d   = Parity_EN;
               ptype_d = Parity_TYPE;
               perr_d  = 1'b0;
            end
         end
         START: begin
            if (at_vote && vote) state_d = IDLE;
            else if (at_last) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (at_vote) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
            if (at_last) begin
               if (bit_q == B_LAST) state_d = pen_q ? PARITY : STOP;
               else bit_d = bit_q + 1'b1;
            end
         end
         PARITY: begin
            if (at_vote) perr_d = vote != ((^shift_q) ^ ptype_q);
            if (at_last) state_d = STOP;
         end
         STOP: begin
            // results are taken mid-stop-bit so IDLE is back before the next start edge
            if (at_vote) begin
               se_d    = ~vote;
               pe_d    = perr_q;
               dv_d    = vote & ~perr_q;
               data_d  = dv_d ? shift_q : data_q;
               state_d = vote ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            edge_d = '0;
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         edge_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         s0_q    <= 1'b1;
         s1_q    <= 1'b1;
         pen_q   <= 1'b0;
         ptype_q <= 1'b0;
         perr_q  <= 1'b0;
         dv_q    <= 1'b0;
         pe_q    <= 1'b0;
         se_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= {sync_q[0], RX_IN};
         edge_q  <= edge_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         pen_q   <= pen_d;
         ptype_q <= ptype_d;
         perr_q  <= perr_d;
         dv_q    <= dv_d;
         pe_q    <= pe_d;
         se_q    <= se_d;
         busy_q  <= state_d != IDLE;
      end
   end

   assign P_DATA       = data_q;
   assign Data_Valid   = dv_q;
   assign Parity_Error = pe_q;
   assign Stop_Error   = se_q;
   assign Busy         = busy_q;
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: scoreboard bench for uart_rx_fsm; expected pulses are queued
// when a frame is driven and matched against the DUT result pulses.
module tb_uart_rx_fsm;
   localparam int OS = 8;

   logic       Clk = 1'b0, Reset = 1'b1, RX_IN = 1'b1, Parity_EN = 1'b0, Parity_TYPE = 1'b0;
   logic [7:0] P_DATA;
   logic       Data_Valid, Parity_Error, Stop_Error, Busy;
   int unsigned cyc = 0;
   int         n_chk = 0, n_err = 0;
   logic [7:0] last_good = 8'h00;

   typedef struct {
      logic [7:0]  data;
      logic        dv, pe, se;
      int unsigned at;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   uart_rx_fsm #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
      .Clk(Clk), .Reset(Reset), .RX_IN(RX_IN), .Parity_EN(Parity_EN), .Parity_TYPE(Parity_TYPE),
      .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Parity_Error(Parity_Error),
      .Stop_Error(Stop_Error), .Busy(Busy)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      RX_IN = b;
      idle(OS);
   endtask

   // RX_IN changes now; rx_s sees it 2 cycles later (t0); pulse at t0 + S*OS + OS/2 + 2
   task automatic send(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb,
                       input logic dv, input logic pe, input logic se);
      exp_t e;
      int   s;
      s = pen ? 10 : 9;
      if (dv) last_good = d;
      e.data = last_good;
      e.dv   = dv;
      e.pe   = pe;
      e.se   = se;
      e.at   = cyc + 2 + s * OS + OS / 2 + 2;
      sb.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pen) drive_bit(pbit);
      drive_bit(stopb);
   endtask

   task automatic busy_probe();
      int unsigned t0;
      t0 = cyc + 2;
      while (cyc != t0) @(negedge Clk);
      chk("busy_t0", Busy, 0);
      while (cyc != t0 + 1) @(negedge Clk);
      chk("busy_t0+1", Busy, 1);
      while (cyc != t0 + 77) @(negedge Clk);
      chk("busy_t0+77", Busy, 1);
   endtask

   always @(negedge Clk) begin
      if (!Reset && (Data_Valid || Parity_Error || Stop_Error)) begin
         if (sb.size() == 0) chk("unexpected_pulse", {Data_Valid, Parity_Error, Stop_Error}, 0);
         else begin
            mon_e = sb.pop_front();
            chk("cycle", cyc, mon_e.at);
            chk("data_valid", Data_Valid, mon_e.dv);
            chk("parity_error", Parity_Error, mon_e.pe);
            chk("stop_error", Stop_Error, mon_e.se);
            chk("p_data", P_DATA, mon_e.data);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0;
      logic [7:0]  d;
      idle(3);
      chk("rst_p_data", P_DATA, 0);
      chk("rst_dv", Data_Valid, 0);
      chk("rst_pe", Parity_Error, 0);
      chk("rst_se", Stop_Error, 0);
      chk("rst_busy", Busy, 0);
      Reset = 1'b0;
      idle(5);

      fork
         send(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         busy_probe();
      join
      idle(10);

      Parity_EN = 1'b1;
      Parity_TYPE = 1'b0;
      send(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      Parity_TYPE = 1'b1;
      send(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(10);
      Parity_EN = 1'b0;
      Parity_TYPE = 1'b0;
      idle(5);

      t0 = cyc + 2;
      RX_IN = 1'b0;
      idle(3);
      RX_IN = 1'b1;
      while (cyc != t0 + OS / 2 + 1) @(negedge Clk);
      chk("glitch_busy_hi", Busy, 1);
      @(negedge Clk);
      chk("glitch_busy_lo", Busy, 0);
      idle(10);
      send(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);

      send(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(40);
      chk("wait_high_busy", Busy, 1);
      RX_IN = 1'b1;
      idle(10);
      chk("after_high_busy", Busy, 0);
      send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);

      send(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(10);

      d = 8'hF0;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      RX_IN = d[4];
      idle(3);
      chk("busy_before_rst", Busy, 1);
      Reset = 1'b1;
      RX_IN = 1'b1;
      #1;
      chk("midrst_p_data", P_DATA, 0);
      chk("midrst_dv", Data_Valid, 0);
      chk("midrst_pe", Parity_Error, 0);
      chk("midrst_se", Stop_Error, 0);
      chk("midrst_busy", Busy, 0);
      last_good = 8'h00;
      idle(2);
      Reset = 1'b0;
      idle(10);
      send(8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
